cordic_sincos_iter: RTL
=======================

Name: cordic_sincos_iter

Overview:
Parametrised iterative CORDIC engine that produces cosine and sine together for a signed fixed-point angle in radians. It succeeds the single-output cosine block and adds:
- configurable width and iteration count;
- a valid/ready handshake on both sides, with output backpressure;
- an out-of-range flag.

It sits behind the float-to-fixed front end and feeds the trig result bus.

Parameters:
WIDTH, 32, data width of the angle and results; legal range 16..32.
ITER, 24, CORDIC micro-rotations per sample; legal range 8..WIDTH-2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clk_en  input  1  global enable; when low, all state holds.
in_valid  input  1  angle is valid.
in_ready  output  1  engine can accept an angle.
angle  input  WIDTH  signed Q3.(WIDTH-3) radians.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
cos_out  output  WIDTH  signed Q2.(WIDTH-2).
sin_out  output  WIDTH  signed Q2.(WIDTH-2).
out_err  output  1  input angle exceeded the supported range.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE;
  - in_ready=1, out_valid=0, cos_out=0, sin_out=0, out_err=0;
  - iteration counter goes to 0;
  - any in-flight sample is discarded.
- clk_en=0: no state, register or counter changes. Handshakes do not complete.
- FSM states: IDLE, ROTATE, HOLD.
  - IDLE:
    - in_ready=1.
    - On in_valid&clk_en: x=K, y=0, z=folded angle, i=0, latch err; go to ROTATE.
  - ROTATE:
    - in_ready=0.
    - Each enabled cycle, with d=sign(z): x-=d*(y>>>i), y+=d*(x>>>i), z-=d*atan(2^-i), i++.
    - After iteration ITER-1, register the results (sign-corrected if folded) and go to HOLD.
  - HOLD:
    - out_valid=1; outputs are stable.
    - On out_ready&clk_en: out_valid drops next cycle; go to IDLE.
- Latency from input handshake to out_valid is ITER+1 enabled cycles. Throughput is one sample per ITER+2 cycles, assuming out_ready is high.
- Result stability: the output holds indefinitely while out_ready=0. in_ready stays 0 in that time, so no sample is lost or overwritten.
- Arithmetic:
  - K=0.607252935, pre-applied so no post-scaling is needed.
  - Internal x/y/z are WIDTH+2 bits to absorb growth; outputs are truncated back to WIDTH.
  - 1.0 is represented as 2^(WIDTH-2).
  - Shifts are arithmetic.
- Range, without the optional feature:
  - supported |angle| ≤ pi/2;
  - a larger |angle| sets out_err=1 with the result, and the values carry no accuracy guarantee.
- Accuracy: |error| ≤ 2^-(ITER-2) for cos and for sin.
- Boundary inputs:
  - angle=0 gives cos=K*prod(gain), within tolerance of 1.0, and sin ≈ 0.
  - The most-negative angle code sets out_err.

Optional Feature:
Macro CORDIC_QUAD_EXT_EN.
- Defined: quadrant folding extends the supported range to |angle| ≤ pi.
  - angle > pi/2: z=angle-pi, and both outputs are negated.
  - angle < -pi/2: z=angle+pi, and both outputs are negated.
  - out_err is set only when |angle| > pi.
  - Folding and negation are registered with the sample, so latency is unchanged.
- Undefined: no folding logic; out_err threshold is pi/2.

Decomposition:
- Package cordic_pkg:
  - ATAN_TABLE: 30 entries, atan(2^-i) in Q3.29; slice by >> (32-WIDTH).
  - K_Q2_30 = 32'h26DD3B6A.
  - PI_Q3_29 = 32'h6487ED51.
  - HALF_PI_Q3_29 = 32'h3243F6A9.
  - FSM state enum.
- Sub-module cordic_fold: combinational quadrant fold and range check, producing the folded angle, negate flag and err.

Test Plan:
1. Reset mid-ROTATE: assert reset low at cycle 5 of ITER → next edge shows in_ready=1 and out_valid=0. A fresh angle=0 then completes correctly.
2. WIDTH=32, ITER=24, angle=32'h20000000 (1.0 rad) → after 25 cycles: cos ≈ 0.540302, sin ≈ 0.841471, both ±2^-22, and out_err=0.
3. angle=32'hE0000000 (-1.0) → cos ≈ 0.540302, sin ≈ -0.841471; then angle=0 → cos ≈ 1.0 (32'h40000000 ±2^8 LSB), sin ≈ 0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, a second in_valid is not accepted. Release → the next sample is accepted the cycle after IDLE.
5. clk_en toggling every other cycle with angle 0.5 (32'h10000000) → latency doubles to 50 cycles; cos ≈ 0.877583, sin ≈ 0.479426.
6. angle=2.5 rad (32'h50000000): without the macro → out_err=1. With CORDIC_QUAD_EXT_EN → cos ≈ -0.801144, sin ≈ 0.598472, out_err=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the iterative CORDIC sin/cos engine.
// Angles use Q3.29 and gains use Q2.30 at full 32-bit precision. Narrower builds
// keep the top WIDTH bits of each constant.
package cordic_pkg;

  localparam logic [31:0] K_Q2_30       = 32'h26DD3B6A;
  localparam logic [31:0] PI_Q3_29      = 32'h6487ED51;
  localparam logic [31:0] HALF_PI_Q3_29 = 32'h3243F6A9;

  // atan(2^-i) in Q3.29 for i = 0..29
  localparam logic [31:0] ATAN_TABLE [30] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753, 32'h01FF55BB,
    32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB, 32'h001FFFF5, 32'h000FFFFF,
    32'h00080000, 32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
    32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001
  };

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    HOLD
  } state_t;

endpackage

// File: rtl/cordic_fold.sv
// Combinational quadrant fold and range check for the incoming angle.
// Optional macro CORDIC_QUAD_EXT_EN: fold |angle| in (pi/2, pi] back into
// [-pi/2, pi/2] and flag the result for negation. Without it, anything beyond
// pi/2 is only flagged.
module cordic_fold
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH+1:0] z_fold,
  output logic                    negate,
  output logic                    err
);

  localparam logic signed [WIDTH+1:0] HALF_PI = signed'({2'b00, HALF_PI_Q3_29[31 -: WIDTH]});
`ifdef CORDIC_QUAD_EXT_EN
  localparam logic signed [WIDTH+1:0] PI = signed'({2'b00, PI_Q3_29[31 -: WIDTH]});
`endif

  logic signed [WIDTH+1:0] a_ext;

  assign a_ext = {{2{angle[WIDTH-1]}}, angle};

  // Fold into the CORDIC convergence range and decide whether the angle is supported
  always_comb begin
    z_fold = a_ext;
    negate = 1'b0;
`ifdef CORDIC_QUAD_EXT_EN
    err = (a_ext > PI) || (a_ext < -PI);
    if (a_ext > HALF_PI) begin
      z_fold = a_ext - PI;
      negate = 1'b1;
    end else if (a_ext < -HALF_PI) begin
      z_fold = a_ext + PI;
      negate = 1'b1;
    end
`else
    err = (a_ext > HALF_PI) || (a_ext < -HALF_PI);
`endif
  end

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC engine: one micro-rotation per enabled cycle, cos and sin
// produced together. Valid/ready on both sides, and the result holds while the
// consumer stalls. Optional macro CORDIC_QUAD_EXT_EN (in cordic_fold) extends
// the supported angle range to +/-pi.
module cordic_sincos_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out,
  output logic                    out_err
);

  localparam int IW = WIDTH + 2;
  localparam logic signed [IW-1:0] K_INIT = signed'({2'b00, K_Q2_30[31 -: WIDTH]});
  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t state, state_nxt;
  logic   accept;

  logic signed [IW-1:0] x, y, z;
  logic signed [IW-1:0] x_nxt, y_nxt, z_nxt, atan_i;
  logic [4:0]           iter;
  logic                 neg, err_lat;

  logic signed [IW-1:0] z_fold;
  logic                 fold_neg, fold_err;

  // Drop the guard bits and apply the quadrant sign correction
  function automatic logic signed [WIDTH-1:0] out_word(input logic [WIDTH-1:0] v,
                                                       input logic neg_f);
    return signed'(neg_f ? -v : v);
  endfunction

  cordic_fold #(.WIDTH(WIDTH)) u_fold (
    .angle  (angle),
    .z_fold (z_fold),
    .negate (fold_neg),
    .err    (fold_err)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && clk_en) begin
          accept    = 1'b1;
          state_nxt = ROTATE;
        end
      end
      ROTATE: begin
        if (clk_en && iter == LAST) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready && clk_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    atan_i = signed'(IW'(ATAN_TABLE[iter] >> (32 - WIDTH)));
    if (!z[IW-1]) begin
      x_nxt = x - (y >>> iter);
      y_nxt = y + (x >>> iter);
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + (y >>> iter);
      y_nxt = y - (x >>> iter);
      z_nxt = z + atan_i;
    end
  end

  // Rotation vector: loaded on accept, advanced while rotating
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (accept) begin
        x   <= K_INIT;
        y   <= '0;
        z   <= z_fold;
        neg <= fold_neg;
      end else if (state == ROTATE) begin
        x <= x_nxt;
        y <= y_nxt;
        z <= z_nxt;
      end
    end
  end

  // Iteration counter, error latch and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter    <= '0;
      err_lat <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
      out_err <= 1'b0;
    end else if (clk_en) begin
      if (accept) begin
        iter    <= '0;
        err_lat <= fold_err;
      end else if (state == ROTATE) begin
        iter <= iter + 5'd1;
        if (iter == LAST) begin
          cos_out <= out_word(x_nxt[WIDTH-1:0], neg);
          sin_out <= out_word(y_nxt[WIDTH-1:0], neg);
          out_err <= err_lat;
        end
      end
    end
  end

endmodule
